uart_rx_fifo_ctrl: RTL and testbench

//  Receive-side controller between uart_receiver and uart_regs. It drains the receive

---
 rtl/uart_rx_fifo_ctrl_if.sv | 29 ++
 rtl/uart_rx_fifo_ctrl.sv | 63 ++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_ctrl_if.sv
// uart_rx_fifo_ctrl_if: receiver-side and CPU-side signals of the receive FIFO controller
interface uart_rx_fifo_ctrl_if #(
  parameter int AW = 2
);
  logic          enable_i;
  logic          rsr_full_i;
  logic [7:0]    rsr_byte_i;
  logic          ferr_i;
  logic          perr_i;
  logic          rsr_pull_o;
  logic          rd_i;
  logic [7:0]    rdata_o;
  logic          rferr_o;
  logic          rperr_o;
  logic          urxda_o;
  logic [AW:0]   cnt_o;
  logic [1:0]    urxisel_i;
  logic          oerr_o;
  logic          oerr_clr_i;
  logic          rx_irq_o;
  modport slave (
    input  enable_i, rsr_full_i, rsr_byte_i, ferr_i, perr_i, rd_i, urxisel_i, oerr_clr_i,
    output rsr_pull_o, rdata_o, rferr_o, rperr_o, urxda_o, cnt_o, oerr_o, rx_irq_o
  );
  modport master (
    output enable_i, rsr_full_i, rsr_byte_i, ferr_i, perr_i, rd_i, urxisel_i, oerr_clr_i,
    input  rsr_pull_o, rdata_o, rferr_o, rperr_o, urxda_o, cnt_o, oerr_o, rx_irq_o
  );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: drains the RSR into a flagged byte FIFO with overrun detection and receive interrupt
module uart_rx_fifo_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst_n,
  uart_rx_fifo_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PULL, WAIT} state_t;
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_HIGH = (AW+1)'(DEPTH - 1);
  state_t r_state, w_next;
  logic [9:0] r_mem [DEPTH];
  logic [9:0] w_head;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_cnt, w_cnt;
  logic r_oerr, r_irq, w_flush, w_full, w_empty, w_wr, w_rd, w_oerr_set, w_hit;
  assign w_flush = !bus.enable_i || bus.oerr_clr_i;
  assign w_full = r_cnt == L_FULL;
  assign w_empty = r_cnt == '0;
  assign w_wr = r_state == PULL && !w_flush;
  assign w_rd = bus.rd_i && !w_empty && !w_flush;
  assign w_oerr_set = r_state == IDLE && !w_flush && bus.rsr_full_i && w_full && !bus.rd_i;
  assign w_cnt = r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
  assign w_hit = bus.urxisel_i == 2'b01 ? w_cnt == L_HIGH : bus.urxisel_i == 2'b10 ? w_cnt == L_FULL : 1'b1;
  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];
  always_comb begin
    w_next = r_state;
    w_next = w_flush ? IDLE :
             r_state == IDLE ? (bus.rsr_full_i && !w_full && !r_oerr ? PULL : IDLE) :
             r_state == PULL ? WAIT :
             bus.rsr_full_i ? WAIT : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt <= '0;
      r_oerr <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_state <= w_next;
      r_oerr <= !w_flush && (r_oerr || w_oerr_set);
      r_irq <= (w_oerr_set && !r_oerr) || (w_wr && w_hit);
      r_wr_ptr <= w_flush ? '0 : r_wr_ptr + AW'(w_wr);
      r_rd_ptr <= w_flush ? '0 : r_rd_ptr + AW'(w_rd);
      r_cnt <= w_flush ? '0 : w_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {bus.perr_i, bus.ferr_i, bus.rsr_byte_i};
  end
  assign bus.rsr_pull_o = w_wr;
  assign bus.rdata_o = w_head[7:0];
  assign bus.rferr_o = w_head[8];
  assign bus.rperr_o = w_head[9];
  assign bus.urxda_o = !w_empty;
  assign bus.cnt_o = r_cnt;
  assign bus.oerr_o = r_oerr;
  assign bus.rx_irq_o = r_irq;
endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// tb_uart_rx_fifo_ctrl: vector table, corner sequences and randomized run against a queue model
module tb_uart_rx_fifo_ctrl;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0, pull_cnt = 0, irq_cnt = 0;
  uart_rx_fifo_ctrl_if #(.AW(2)) bus();
  uart_rx_fifo_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.rsr_pull_o) pull_cnt++;
    if (bus.rx_irq_o) irq_cnt++;
  end
  typedef struct {
    logic en, full;
    logic [7:0] b;
    logic fe, pe, rd, pull;
    logic [2:0] cnt;
    logic [7:0] rdata;
    logic rfe, rpe, irq;
  } vec_t;
  vec_t tv[16];
  logic [9:0] q[$];
  logic [9:0] head;
  logic m_pulling, m_blocked, m_oerr, m_irq, rx_has, rx_gap, flush, rise, start, wrote, idle;
  int sz0, rd_rate, p0, i0;
  bit ok;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [16:0] outs();
    return {bus.rsr_pull_o, bus.urxda_o, bus.cnt_o, bus.rdata_o, bus.rferr_o, bus.rperr_o, bus.oerr_o, bus.rx_irq_o};
  endfunction
  task automatic wait_pull();
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.rsr_pull_o) ok = 1'b1;
    end
    chk("pull_seen", 32'(ok), 1);
  endtask
  task automatic send(input logic [7:0] b, input logic fe, input logic pe);
    bus.rsr_byte_i = b;
    bus.ferr_i = fe;
    bus.perr_i = pe;
    bus.rsr_full_i = 1'b1;
    wait_pull();
    bus.rsr_full_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic flush_fifo();
    bus.oerr_clr_i = 1'b1;
    @(posedge clk); #1;
    bus.oerr_clr_i = 1'b0;
  endtask
  initial begin
    bus.enable_i = 1'b1;
    bus.rsr_full_i = 1'b0;
    bus.rsr_byte_i = 8'h00;
    bus.ferr_i = 1'b0;
    bus.perr_i = 1'b0;
    bus.rd_i = 1'b0;
    bus.urxisel_i = 2'b00;
    bus.oerr_clr_i = 1'b0;
    #3;
    chk("reset", 32'(outs()), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    tv[0] = '{1, 0, 8'hA5, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0};
    tv[1] = '{1, 1, 8'hA5, 0, 1, 0, 1, 0, 8'h00, 0, 0, 0};
    tv[2] = '{1, 1, 8'hA5, 0, 1, 0, 0, 1, 8'hA5, 0, 1, 1};
    for (int i = 3; i < 8; i++) tv[i] = '{1, 1, 8'hA5, 0, 1, 0, 0, 1, 8'hA5, 0, 1, 0};
    tv[8] = '{1, 0, 8'hA5, 0, 1, 0, 0, 1, 8'hA5, 0, 1, 0};
    tv[9] = '{1, 0, 8'hA5, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0};
    tv[10] = '{1, 0, 8'hA5, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0};
    tv[11] = '{1, 1, 8'h3C, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0};
    tv[12] = '{0, 1, 8'h3C, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0};
    tv[13] = '{1, 1, 8'h3C, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0};
    tv[14] = '{1, 1, 8'h3C, 1, 0, 0, 0, 1, 8'h3C, 1, 0, 1};
    tv[15] = '{1, 0, 8'h3C, 1, 0, 0, 0, 1, 8'h3C, 1, 0, 0};
    for (int i = 0; i < 16; i++) begin
      bus.enable_i = tv[i].en;
      bus.rsr_full_i = tv[i].full;
      bus.rsr_byte_i = tv[i].b;
      bus.ferr_i = tv[i].fe;
      bus.perr_i = tv[i].pe;
      bus.rd_i = tv[i].rd;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({tv[i].pull, tv[i].cnt != 3'd0, tv[i].cnt, tv[i].rdata, tv[i].rfe, tv[i].rpe, 1'b0, tv[i].irq}));
    end
    bus.rd_i = 1'b0;
    bus.rsr_full_i = 1'b0;
    flush_fifo();
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b0);
    chk("ovr_cnt4", 32'(bus.cnt_o), 4);
    bus.rsr_byte_i = 8'h05;
    bus.rsr_full_i = 1'b1;
    p0 = pull_cnt;
    i0 = irq_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("ovr_oerr", 32'(bus.oerr_o), 1);
    chk("ovr_nopull", pull_cnt - p0, 0);
    chk("ovr_irq", irq_cnt - i0, 1);
    chk("ovr_head", 32'(bus.rdata_o), 1);
    flush_fifo();
    chk("ovr_clr", 32'({bus.oerr_o, bus.cnt_o}), 0);
    wait_pull();
    bus.rsr_full_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ovr_after", 32'({bus.cnt_o, bus.rdata_o}), 32'({3'd1, 8'h05}));
    flush_fifo();
    bus.urxisel_i = 2'b01;
    i0 = irq_cnt;
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    chk("sel01_two", irq_cnt - i0, 0);
    send(8'h33, 1'b0, 1'b0);
    chk("sel01_three", irq_cnt - i0, 1);
    flush_fifo();
    bus.urxisel_i = 2'b10;
    i0 = irq_cnt;
    for (int i = 0; i < 3; i++) send(8'h40 + 8'(i), 1'b0, 1'b0);
    chk("sel10_three", irq_cnt - i0, 0);
    send(8'h44, 1'b0, 1'b0);
    chk("sel10_four", irq_cnt - i0, 1);
    bus.urxisel_i = 2'b00;
    flush_fifo();
    send(8'hA1, 1'b0, 1'b0);
    send(8'hA2, 1'b1, 1'b0);
    bus.rsr_byte_i = 8'hA3;
    bus.rsr_full_i = 1'b1;
    wait_pull();
    bus.rd_i = 1'b1;
    @(posedge clk); #1;
    bus.rd_i = 1'b0;
    chk("coinc", 32'({bus.cnt_o, bus.rdata_o, bus.rferr_o}), 32'({3'd2, 8'hA2, 1'b1}));
    bus.rsr_full_i = 1'b0;
    bus.rd_i = 1'b1;
    @(posedge clk); #1;
    bus.rd_i = 1'b0;
    chk("coinc_next", 32'({bus.cnt_o, bus.rdata_o}), 32'({3'd1, 8'hA3}));
    flush_fifo();
    bus.rsr_byte_i = 8'h3C;
    bus.rsr_full_i = 1'b1;
    wait_pull();
    bus.enable_i = 1'b0;
    #1;
    chk("en_drop_pull", 32'(bus.rsr_pull_o), 0);
    @(posedge clk); #1;
    chk("en_drop", 32'({bus.cnt_o, bus.urxda_o, bus.oerr_o}), 0);
    bus.enable_i = 1'b1;
    bus.rsr_full_i = 1'b0;
    @(posedge clk); #1;
    bus.rsr_byte_i = 8'h77;
    bus.rsr_full_i = 1'b1;
    wait_pull();
    @(posedge clk); #1;
    chk("wait_cnt", 32'(bus.cnt_o), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 32'(outs()), 0);
    bus.rsr_full_i = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_after", 32'(outs()), 0);
    q.delete();
    {m_pulling, m_blocked, m_oerr, m_irq, rx_has} = '0;
    rx_gap = 1'b1;
    rd_rate = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 250 == 0) begin
        rd_rate = $urandom_range(0, 6);
        bus.urxisel_i = 2'($urandom_range(0, 3));
      end
      if (!rx_has && rx_gap && $urandom_range(0, 2) == 0) begin
        rx_has = 1'b1;
        bus.rsr_byte_i = 8'($urandom);
        bus.ferr_i = 1'($urandom);
        bus.perr_i = 1'($urandom);
      end
      bus.rsr_full_i = rx_has;
      bus.enable_i = $urandom_range(0, 99) != 0;
      bus.oerr_clr_i = $urandom_range(0, 99) == 0;
      bus.rd_i = $urandom_range(0, 7) < rd_rate;
      #1;
      flush = !bus.enable_i || bus.oerr_clr_i;
      head = q.size() != 0 ? q[0] : 10'd0;
      chk("rand", 32'(outs()),
          32'({m_pulling && !flush, q.size() != 0, 3'(q.size()), head[7:0], head[8], head[9], m_oerr, m_irq}));
      if (flush) begin
        q.delete();
        {m_pulling, m_blocked, m_oerr, m_irq} = '0;
        rx_gap = 1'b1;
      end else begin
        sz0 = q.size();
        idle = !m_pulling && !m_blocked;
        rise = idle && rx_has && sz0 == DEPTH && !bus.rd_i && !m_oerr;
        start = idle && rx_has && sz0 < DEPTH && !m_oerr;
        wrote = m_pulling;
        if (bus.rd_i && sz0 > 0) void'(q.pop_front());
        if (wrote) begin
          q.push_back({bus.perr_i, bus.ferr_i, bus.rsr_byte_i});
          rx_has = 1'b0;
        end
        rx_gap = !wrote;
        m_irq = rise || (wrote && (bus.urxisel_i == 2'b01 ? q.size() == DEPTH - 1 :
                                   bus.urxisel_i == 2'b10 ? q.size() == DEPTH : 1'b1));
        m_blocked = wrote || (m_blocked && rx_has);
        m_pulling = start;
        m_oerr = m_oerr || rise;
      end
      @(posedge clk); #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
